adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 25 ++
 rtl/adder_arbiter_rr_pick.sv | 38 +++
 rtl/adder_arbiter.sv | 102 ++++++++++
 tb/tb_adder_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module   : adder_arb_pkg
// Brief    : Shared defaults, id-width helper and FSM encoding for adder_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

  localparam int C_N_REQ = 4;
  localparam int C_WIDTH = 8;

  // Keeps the index at least one bit wide for a single-requester build
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int C_ID_W = id_w(C_N_REQ);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Round-robin selector, searching upward from last_grant+1
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    w_cand = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = ID_W'((int'(last_grant_i) + off) % N_REQ);
      if (!any_o && req_i[w_cand]) begin
        any_o         = 1'b1;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module   : adder_arbiter
// Brief    : N requesters share one adder through a round-robin grant
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = C_N_REQ,
  parameter int WIDTH = C_WIDTH,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  input  logic                   rsp_ready
);

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_en;
  logic             w_accept;
  logic [WIDTH-1:0] w_a, w_b, w_sum;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (w_gnt),
    .idx_o        (w_idx),
    .any_o        (w_any)
  );

  // Grants are only offered when the result slot is free or being drained
  assign w_en     = !rst && ((state_q == C_IDLE) || rsp_ready);
  assign w_accept = w_en && w_any;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == ID_W'(i)) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sum = w_a + w_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (w_accept) state_d = C_BUSY;
      C_BUSY:  if (rsp_ready && !w_accept) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == C_BUSY);
    req_ready = w_en ? w_gnt : '0;
    rsp_id    = rsp_id_q;
    rsp_sum   = rsp_sum_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
    end else if (w_accept) begin
      last_grant_q <= w_idx;
      rsp_id_q     <= w_idx;
      rsp_sum_q    <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// Module   : tb_adder_arbiter
// Brief    : Directed scoreboard bench for adder_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_ready;

  int total = 0;
  int bad   = 0;
  logic [9:0] q[$];

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with inputs already driven
  task automatic cycle(input logic [3:0] exp_rdy);
    logic [7:0] s;
    #3;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
    if (rsp_valid && q.size() != 0) begin
      check("rsp_id_sum", 32'({rsp_id, rsp_sum}), 32'(q[0]));
      if (rsp_ready) void'(q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        s = req_a[i*8 +: 8] + req_b[i*8 +: 8];
        q.push_back({2'(i), s});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'h0);

    // single request, 55+AA
    rst       = 1'b0;
    req_valid = 4'b0001;
    req_a     = 32'h0000_0055;
    req_b     = 32'h0000_00AA;
    cycle(4'b0001);
    req_valid = 4'b0000;
    check("first_sum", 32'(rsp_sum), 32'hFF);
    cycle(4'b0000);
    cycle(4'b0000);

    // wrap-around on requester 2
    req_valid = 4'b0100;
    req_a     = 32'h00FF_0000;
    req_b     = 32'h0001_0000;
    cycle(4'b0100);
    req_valid = 4'b0000;
    check("wrap_sum", 32'(rsp_sum), 32'h00);
    cycle(4'b0000);
    cycle(4'b0000);

    // park last grant on 3, then full contention
    req_valid = 4'b1000;
    req_a     = 32'h4030_2010;
    req_b     = 32'h0403_0201;
    cycle(4'b1000);
    req_valid = 4'b1111;
    cycle(4'b0001);
    cycle(4'b0010);
    cycle(4'b0100);
    cycle(4'b1000);
    cycle(4'b0001);

    // backpressure: result must hold, no grants
    rsp_ready = 1'b0;
    cycle(4'b0000);
    cycle(4'b0000);
    cycle(4'b0000);
    rsp_ready = 1'b1;
    cycle(4'b0010);
    req_valid = 4'b0000;
    cycle(4'b0000);
    cycle(4'b0000);

    // single active requester granted every cycle
    req_valid = 4'b0100;
    req_a     = 32'h00C0_0000;
    req_b     = 32'h0050_0000;
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0100);
    req_valid = 4'b0000;
    cycle(4'b0000);
    cycle(4'b0000);

    // reset while a result is held
    req_valid = 4'b0001;
    req_a     = 32'h0000_0011;
    req_b     = 32'h0000_0022;
    cycle(4'b0001);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    check("pre_rst_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    req_a     = 32'h0900_0007;
    req_b     = 32'h0100_0003;
    cycle(4'b0001);
    req_valid = 4'b0000;
    cycle(4'b0000);
    cycle(4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
